// File: rtl/cpu_defs.sv
// Shared CPU definitions: mul/div op encodings and the mul/div unit state encoding.
package cpu_defs;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// A single WIDTH+1-bit adder serves both operations, selected by the latched op.
module mul_div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rl,
  output logic [WIDTH-1:0] rh,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             op_reg, op_next;
  logic [WIDTH:0]   acc_reg, acc_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] rl_reg, rl_next;
  logic [WIDTH-1:0] rh_reg, rh_next;
  logic             dz_reg, dz_next;

  // Shared adder: MUL adds the gated multiplicand to the accumulator,
  // DIV adds the inverted divisor plus one to the shifted partial remainder.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_x, add_y;
  logic [WIDTH+1:0] add_sum;
  logic             add_carry;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;

  assign shifted   = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign add_x     = op_reg ? shifted : {1'b0, acc_reg[WIDTH-1:0]};
  assign add_y     = op_reg ? ~{1'b0, b_reg} : {1'b0, b_reg & {WIDTH{q_reg[0]}}};
  assign add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, op_reg};
  assign add_carry = add_sum[WIDTH+1];

  always_comb begin
    step_acc = acc_reg;
    step_q   = q_reg;
    if (op_reg == MD_OP_MUL) begin
      step_acc = {1'b0, add_sum[WIDTH:1]};
      step_q   = {add_sum[0], q_reg[WIDTH-1:1]};
    end else begin
      // carry out set means the trial subtraction did not borrow
      step_acc = add_carry ? add_sum[WIDTH:0] : shifted;
      step_q   = {q_reg[WIDTH-2:0], add_carry};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    b_next     = b_reg;
    rl_next    = rl_reg;
    rh_next    = rh_reg;
    dz_next    = dz_reg;
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          op_next  = op;
          b_next   = b;
          acc_next = '0;
          q_next   = a;
          cnt_next = CW'(WIDTH);
          if (op == MD_OP_DIV && b == '0) begin
            state_next = MD_DONE;
            rl_next    = '1;
            rh_next    = a;
            dz_next    = 1'b1;
          end else begin
            state_next = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        acc_next = step_acc;
        q_next   = step_q;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = MD_DONE;
          rl_next    = step_q;
          rh_next    = step_acc[WIDTH-1:0];
          dz_next    = 1'b0;
        end
      end
      MD_DONE: begin
        state_next = MD_IDLE;
      end
      default: begin
        state_next = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
      op_reg    <= MD_OP_MUL;
      acc_reg   <= '0;
      q_reg     <= '0;
      b_reg     <= '0;
      rl_reg    <= '0;
      rh_reg    <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      b_reg     <= b_next;
      rl_reg    <= rl_next;
      rh_reg    <= rh_next;
      dz_reg    <= dz_next;
    end
  end

  assign busy     = (state_reg != MD_IDLE);
  assign done     = (state_reg == MD_DONE);
  assign rl       = rl_reg;
  assign rh       = rh_reg;
  assign div_zero = dz_reg;

endmodule
